// File: rtl/wc_pad_gearbox.sv
// -----------------------------------------------------------------------------
// wc_pad_gearbox
//
// Pad-side gearbox between the chip I/O ring and the Winograd core. The input
// side reassembles IN_LANES-wide pad beats into one N_IN-word core operand
// vector. The output side buffers N_OUT-word core result vectors in a small
// FIFO and serialises them onto OUT_LANES-wide pad beats, with off-chip
// backpressure.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst          asynchronous reset, active low
//   pad_din      input beat, lane j at [j*DW +: DW]
//   pad_dvalid   input beat qualifier
//   pad_dsof     first beat of an input frame (qualified by pad_dvalid)
//   core_d       assembled operand vector, word w at [w*DW +: DW]
//   core_dvalid  one-cycle pulse when core_d carries a new vector
//   core_z       core result vector
//   core_zvalid  result strobe (no backpressure towards the core)
//   pad_zout     output beat
//   pad_zvalid   output beat valid
//   pad_zsof     first beat of an output frame
//   pad_zready   off-chip accept
//   ovf          sticky: a result vector was dropped on a full FIFO
//   err_sof      sticky: input framing error seen
// -----------------------------------------------------------------------------
module wc_pad_gearbox #(
  parameter int DW         = 10,
  parameter int N_IN       = 6,
  parameter int N_OUT      = 2,
  parameter int IN_LANES   = 2,
  parameter int OUT_LANES  = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_LANES*DW-1:0]    pad_din,
  input  logic                      pad_dvalid,
  input  logic                      pad_dsof,
  output logic [N_IN*DW-1:0]        core_d,
  output logic                      core_dvalid,
  input  logic [N_OUT*DW-1:0]       core_z,
  input  logic                      core_zvalid,
  output logic [OUT_LANES*DW-1:0]   pad_zout,
  output logic                      pad_zvalid,
  output logic                      pad_zsof,
  input  logic                      pad_zready,
  output logic                      ovf,
  output logic                      err_sof
);

  localparam int IB     = N_IN / IN_LANES;
  localparam int OB     = N_OUT / OUT_LANES;
  localparam int ICW    = (IB > 1) ? $clog2(IB) : 1;
  localparam int OCW    = (OB > 1) ? $clog2(OB) : 1;
  localparam int PW     = $clog2(OBUF_DEPTH);
  localparam int BW_IN  = IN_LANES * DW;
  localparam int BW_OUT = OUT_LANES * DW;
  localparam int VW_IN  = N_IN * DW;
  localparam int VW_OUT = N_OUT * DW;

  // Select output beat idx of a result vector. Looping over constant slice
  // positions keeps every part-select in range for any OB, including OB=1.
  function automatic logic [BW_OUT-1:0] out_beat(input logic [VW_OUT-1:0] v,
                                                 input logic [OCW-1:0]    idx);
    out_beat = '0;
    for (int b = 0; b < OB; b++) begin
      if (OCW'(b) == idx) out_beat = v[b*BW_OUT +: BW_OUT];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: deserialiser (pad beat -> shadow vector -> core_d)
  // ---------------------------------------------------------------------------
  logic [ICW-1:0]   in_cnt_p0;
  logic [ICW-1:0]   slot_p0;
  logic             accept_p0;
  logic             last_p0;
  logic             sof_err_p0;
  logic [VW_IN-1:0] shadow_p0;
  logic [VW_IN-1:0] frame_p0;

  always_comb begin
    // A sof beat always restarts the frame at slot 0; a non-sof beat is only
    // meaningful inside a frame that has already started.
    slot_p0    = pad_dsof ? '0 : in_cnt_p0;
    accept_p0  = pad_dvalid & (pad_dsof | (in_cnt_p0 != '0));
    last_p0    = accept_p0 & (slot_p0 == ICW'(IB - 1));
    sof_err_p0 = pad_dvalid & (pad_dsof ? (in_cnt_p0 != '0) : (in_cnt_p0 == '0));
    // Shadow with the current beat merged in, so the final beat reaches
    // core_d in the same edge it is sampled.
    frame_p0   = shadow_p0;
    for (int k = 0; k < IB; k++) begin
      if (ICW'(k) == slot_p0) frame_p0[k*BW_IN +: BW_IN] = pad_din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_p0   <= '0;
      core_dvalid <= 1'b0;
      core_d      <= '0;
      err_sof     <= 1'b0;
    end else begin
      core_dvalid <= last_p0;
      if (sof_err_p0) err_sof <= 1'b1;
      if (last_p0) begin
        in_cnt_p0 <= '0;
        core_d    <= frame_p0;
      end else if (accept_p0) begin
        in_cnt_p0 <= slot_p0 + ICW'(1);
      end
    end
  end

  // Shadow words are pure data: a stale slot is always rewritten before the
  // frame completes, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept_p0) shadow_p0 <= frame_p0;
  end

  // ---------------------------------------------------------------------------
  // Stage p1: output FIFO (core_z -> FIFO)
  // ---------------------------------------------------------------------------
  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              state_p1;
  logic [OCW-1:0]      beat_p1;
  logic [VW_OUT-1:0]   sreg_p1;
  logic [VW_OUT-1:0]   fifo_mem [OBUF_DEPTH];
  logic [PW:0]         wr_ptr_p1;
  logic [PW:0]         rd_ptr_p1;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic [VW_OUT-1:0]   fifo_head;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr_p1 == rd_ptr_p1);
  assign fifo_full  = (wr_ptr_p1[PW] != rd_ptr_p1[PW]) &&
                      (wr_ptr_p1[PW-1:0] == rd_ptr_p1[PW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_p1[PW-1:0]];

  always_comb begin
    // Pop when idle, or when the last beat of the current frame is accepted,
    // giving back-to-back frames with no bubble.
    pop  = !fifo_empty &&
           ((state_p1 == S_IDLE) ||
            (pad_zready && (beat_p1 == OCW'(OB - 1))));
    // A same-cycle pop frees the slot a push on a full FIFO needs.
    push = core_zvalid && (!fifo_full || pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      ovf       <= 1'b0;
    end else begin
      if (push) wr_ptr_p1 <= wr_ptr_p1 + (PW+1)'(1);
      if (pop)  rd_ptr_p1 <= rd_ptr_p1 + (PW+1)'(1);
      if (core_zvalid && !push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_p1[PW-1:0]] <= core_z;
  end

  // ---------------------------------------------------------------------------
  // Stage p2: serialiser (FIFO head -> shift register -> pad beats)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1   <= S_IDLE;
      beat_p1    <= '0;
      pad_zvalid <= 1'b0;
      pad_zsof   <= 1'b0;
      pad_zout   <= '0;
    end else begin
      if (pop) begin
        state_p1   <= S_SEND;
        beat_p1    <= '0;
        pad_zvalid <= 1'b1;
        pad_zsof   <= 1'b1;
        pad_zout   <= out_beat(fifo_head, '0);
      end else if ((state_p1 == S_SEND) && pad_zready) begin
        if (beat_p1 == OCW'(OB - 1)) begin
          state_p1   <= S_IDLE;
          beat_p1    <= '0;
          pad_zvalid <= 1'b0;
          pad_zsof   <= 1'b0;
          pad_zout   <= '0;
        end else begin
          beat_p1  <= beat_p1 + OCW'(1);
          pad_zsof <= 1'b0;
          pad_zout <= out_beat(sreg_p1, beat_p1 + OCW'(1));
        end
      end
    end
  end

  // The frame being sent is held here so the FIFO slot can be reused at once.
  always_ff @(posedge clk) begin
    if (pop) sreg_p1 <= fifo_head;
  end

endmodule

// File: tb/tb_wc_pad_gearbox.sv
// -----------------------------------------------------------------------------
// tb_wc_pad_gearbox
//
// Three gearbox instances with different lane widths (2/1, 6/2 and 1/1) share
// the clock, reset and the core result side. Each instance gets its own pad
// input. A vector-level model of the frame and FIFO rules predicts every
// output each cycle; directed literal checks pin the model down.
// -----------------------------------------------------------------------------
module tb_wc_pad_gearbox;

  localparam int DW    = 10;
  localparam int N_IN  = 6;
  localparam int N_OUT = 2;
  localparam int DEPTH = 4;
  localparam int NI    = 3;
  localparam int VWI   = N_IN * DW;
  localparam int VWO   = N_OUT * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [VWI-1:0] din  [NI];
  logic           dv   [NI];
  logic           dsof [NI];
  logic [VWO-1:0] core_z;
  logic           core_zvalid;
  logic           pad_zready;

  logic [VWI-1:0] cd   [NI];
  logic           cdv  [NI];
  logic [VWO-1:0] zo   [NI];
  logic           zv   [NI];
  logic           zs   [NI];
  logic           ovf  [NI];
  logic           esof [NI];

  function automatic int il(int i);
    return (i == 0) ? 2 : (i == 1) ? 6 : 1;
  endfunction

  function automatic int ol(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int IL = (g == 0) ? 2 : (g == 1) ? 6 : 1;
    localparam int OL = (g == 1) ? 2 : 1;
    logic [VWI-1:0]   cd_w;
    logic             cdv_w;
    logic [OL*DW-1:0] zo_w;
    logic             zv_w;
    logic             zs_w;
    logic             ovf_w;
    logic             esof_w;

    wc_pad_gearbox #(
      .DW(DW), .N_IN(N_IN), .N_OUT(N_OUT),
      .IN_LANES(IL), .OUT_LANES(OL), .OBUF_DEPTH(DEPTH)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_n),
      .pad_din    (din[g][IL*DW-1:0]),
      .pad_dvalid (dv[g]),
      .pad_dsof   (dsof[g]),
      .core_d     (cd_w),
      .core_dvalid(cdv_w),
      .core_z     (core_z),
      .core_zvalid(core_zvalid),
      .pad_zout   (zo_w),
      .pad_zvalid (zv_w),
      .pad_zsof   (zs_w),
      .pad_zready (pad_zready),
      .ovf        (ovf_w),
      .err_sof    (esof_w)
    );

    assign cd[g]   = cd_w;
    assign cdv[g]  = cdv_w;
    assign zo[g]   = VWO'(zo_w);
    assign zv[g]   = zv_w;
    assign zs[g]   = zs_w;
    assign ovf[g]  = ovf_w;
    assign esof[g] = esof_w;
  end

  // ---------------------------------------------------------------------------
  // Counters and the single comparison primitive
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int i,
                     input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[inst %0d] t=%0t got=%h want=%h", nm, i, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: frame counter and words, result queue and frame in flight
  // ---------------------------------------------------------------------------
  int             icnt    [NI];
  logic [VWI-1:0] shadow  [NI];
  logic [VWI-1:0] exp_cd  [NI];
  logic           exp_cdv [NI];
  logic           exp_err [NI];
  logic           exp_ovf [NI];
  logic           busy    [NI];
  int             beat    [NI];
  int             fcnt    [NI];
  logic [VWO-1:0] cur     [NI];
  logic [VWO-1:0] fq      [NI][DEPTH];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      icnt[i] = 0; shadow[i] = '0; exp_cd[i] = '0; exp_cdv[i] = 1'b0;
      exp_err[i] = 1'b0; exp_ovf[i] = 1'b0; busy[i] = 1'b0;
      beat[i] = 0; fcnt[i] = 0; cur[i] = '0;
    end
  endtask

  task automatic model_step(input int i);
    int ib, ob, slot;
    bit acc, pop;
    ib = N_IN / il(i);
    ob = N_OUT / ol(i);
    exp_cdv[i] = 1'b0;
    if (dv[i]) begin
      acc  = 1'b1;
      slot = icnt[i];
      if (dsof[i]) begin
        if (icnt[i] != 0) exp_err[i] = 1'b1;
        slot = 0;
      end else if (icnt[i] == 0) begin
        exp_err[i] = 1'b1;
        acc = 1'b0;
      end
      if (acc) begin
        for (int j = 0; j < il(i); j++)
          shadow[i][(slot*il(i)+j)*DW +: DW] = din[i][j*DW +: DW];
        icnt[i] = slot + 1;
        if (icnt[i] == ib) begin
          exp_cd[i]  = shadow[i];
          exp_cdv[i] = 1'b1;
          icnt[i]    = 0;
        end
      end
    end
    pop = 1'b0;
    if (!busy[i]) begin
      pop = (fcnt[i] > 0);
    end else if (pad_zready) begin
      if (beat[i] == ob - 1) begin
        busy[i] = 1'b0;
        pop = (fcnt[i] > 0);
      end else begin
        beat[i]++;
      end
    end
    if (pop) begin
      cur[i] = fq[i][0];
      for (int k = 0; k < DEPTH - 1; k++) fq[i][k] = fq[i][k+1];
      fcnt[i]--;
      busy[i] = 1'b1;
      beat[i] = 0;
    end
    if (core_zvalid) begin
      if (fcnt[i] < DEPTH) begin
        fq[i][fcnt[i]] = core_z;
        fcnt[i]++;
      end else begin
        exp_ovf[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [VWO-1:0] exp_beat(input int i);
    logic [VWO-1:0] r;
    r = '0;
    for (int j = 0; j < ol(i); j++)
      r[j*DW +: DW] = cur[i][(beat[i]*ol(i)+j)*DW +: DW];
    return r;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < NI; i++) model_step(i);
    end
  end

  // Compare every instance against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("core_d",      i, cd[i],   exp_cd[i]);
        chk("core_dvalid", i, cdv[i],  exp_cdv[i]);
        chk("err_sof",     i, esof[i], exp_err[i]);
        chk("ovf",         i, ovf[i],  exp_ovf[i]);
        chk("pad_zvalid",  i, zv[i],   busy[i]);
        if (busy[i]) begin
          chk("pad_zsof", i, zs[i], (beat[i] == 0));
          chk("pad_zout", i, zo[i], exp_beat(i));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // nb beats of consecutive word values starting at 'first'; sof on beat 0.
  task automatic frame(input int i, input int first, input int nb, input bit sof);
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < il(i); j++)
        din[i][j*DW +: DW] = DW'(first + k*il(i) + j);
      dv[i]   = 1'b1;
      dsof[i] = sof && (k == 0);
      tick();
    end
    dv[i]   = 1'b0;
    dsof[i] = 1'b0;
  endtask

  function automatic logic [VWI-1:0] seqv(input int first);
    logic [VWI-1:0] r;
    r = '0;
    for (int w = 0; w < N_IN; w++) r[w*DW +: DW] = DW'(first + w);
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t run did not complete", $time);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < NI; i++) begin
      din[i] = '0; dv[i] = 1'b0; dsof[i] = 1'b0;
    end
    core_z = '0; core_zvalid = 1'b0; pad_zready = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    for (int i = 0; i < NI; i++) begin
      chk("rst_core_d", i, cd[i], '0);
      chk("rst_zvalid", i, zv[i], 1'b0);
      chk("rst_zout",   i, zo[i], '0);
      chk("rst_ovf",    i, ovf[i], 1'b0);
    end
    rst_n = 1'b1;
    tick();

    // Frame assembly 1..6
    frame(0, 1, 3, 1'b1);
    chk("asm_pulse",   0, cdv[0], 1'b1);
    chk("asm_core_d",  0, cd[0],  seqv(1));
    tick();
    chk("asm_pulse_end", 0, cdv[0], 1'b0);

    // Partial frame restarted by a new sof
    frame(0, 1, 2, 1'b1);
    frame(0, 7, 3, 1'b1);
    chk("restart_core_d", 0, cd[0],   seqv(7));
    chk("restart_err",    0, esof[0], 1'b1);
    tick();

    // Lone non-sof beat while idle
    do_reset();
    frame(0, 1, 3, 1'b1);
    tick();
    frame(0, 20, 1, 1'b0);
    tick();
    chk("lone_err",    0, esof[0], 1'b1);
    chk("lone_core_d", 0, cd[0],   seqv(1));

    // Serialise with a 3-cycle stall
    pad_zready  = 1'b0;
    core_z      = {10'h001, 10'h3FF};
    core_zvalid = 1'b1;
    tick();
    core_zvalid = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("stall_zvalid", 0, zv[0], 1'b1);
      chk("stall_zout",   0, zo[0], 20'h003FF);
      chk("stall_zsof",   0, zs[0], 1'b1);
      chk("stall_zout_w", 1, zo[1], 20'h007FF);
      if (c < 2) tick();
    end
    pad_zready = 1'b1;
    tick();
    chk("ser_beat1_zout", 0, zo[0], 20'h00001);
    chk("ser_beat1_zsof", 0, zs[0], 1'b0);
    chk("ser_beat1_zvld", 0, zv[0], 1'b1);
    tick();
    chk("ser_idle", 0, zv[0], 1'b0);

    // Overflow: 6 results into a stalled serialiser
    pad_zready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      core_z      = {10'(k + 'h80), 10'(k)};
      core_zvalid = 1'b1;
      tick();
    end
    core_zvalid = 1'b0;
    chk("ovf_set",   0, ovf[0], 1'b1);
    chk("ovf_set_w", 1, ovf[1], 1'b1);
    pad_zready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      chk("drain_zout", 0, zo[0], (b % 2) ? 20'(b/2 + 1 + 'h80) : 20'(b/2 + 1));
      chk("drain_zsof", 0, zs[0], (b % 2) == 0);
      chk("drain_zvld", 0, zv[0], 1'b1);
      chk("drain_zout_n1", 2, zo[2], (b % 2) ? 20'(b/2 + 1 + 'h80) : 20'(b/2 + 1));
      tick();
    end
    chk("drain_idle", 0, zv[0], 1'b0);

    // Reset mid-operation
    frame(0, 30, 1, 1'b0);
    pad_zready  = 1'b0;
    core_z      = {10'h2AA, 10'h155};
    core_zvalid = 1'b1;
    tick();
    core_zvalid = 1'b0;
    tick();
    chk("pre_rst_zvalid", 0, zv[0], 1'b1);
    frame(0, 1, 2, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_zvalid", 0, zv[0],   1'b0);
    chk("mid_rst_zout",   0, zo[0],   '0);
    chk("mid_rst_zsof",   0, zs[0],   1'b0);
    chk("mid_rst_core_d", 0, cd[0],   '0);
    chk("mid_rst_ovf",    0, ovf[0],  1'b0);
    chk("mid_rst_err",    0, esof[0], 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    frame(0, 1, 3, 1'b1);
    chk("post_rst_core_d", 0, cd[0],   seqv(1));
    chk("post_rst_pulse",  0, cdv[0],  1'b1);
    chk("post_rst_err",    0, esof[0], 1'b0);
    chk("post_rst_ovf",    0, ovf[0],  1'b0);
    tick();

    // Lane sweep: single-beat and single-word input frames
    frame(1, 1, 1, 1'b1);
    chk("w6_core_d", 1, cd[1],  seqv(1));
    chk("w6_pulse",  1, cdv[1], 1'b1);
    tick();
    frame(2, 1, 6, 1'b1);
    chk("w1_core_d", 2, cd[2],  seqv(1));
    chk("w1_pulse",  2, cdv[2], 1'b1);
    frame(2, 1, 3, 1'b1);
    frame(2, 7, 6, 1'b1);
    chk("w1_restart_core_d", 2, cd[2],   seqv(7));
    chk("w1_restart_err",    2, esof[2], 1'b1);
    tick();
    frame(1, 50, 1, 1'b0);
    tick();
    chk("w6_lone_err",    1, esof[1], 1'b1);
    chk("w6_lone_core_d", 1, cd[1],   seqv(1));

    // Sweep instances through the serialiser once more
    pad_zready  = 1'b1;
    core_z      = {10'h0AB, 10'h0CD};
    core_zvalid = 1'b1;
    tick();
    core_zvalid = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
